// File: rtl/switch_debouncer.sv
// Debounces asynchronous board switches: two-flop sync, per-bit
// stability counter, one-cycle change mask and sticky event flag.
module switch_debouncer #(
  parameter int SWITCH_COUNT  = 18,
  parameter int STABLE_CYCLES = 50000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [0:SWITCH_COUNT-1] raw_switches,
  output logic [0:SWITCH_COUNT-1] switches,
  output logic [0:SWITCH_COUNT-1] change_mask,
  output logic                    changed,
  output logic                    event_pending,
  input  logic                    event_ack
);

  localparam int CW =
    (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [0:SWITCH_COUNT-1] meta;
  logic [0:SWITCH_COUNT-1] sync;
  logic [0:SWITCH_COUNT-1] flip;

  logic [SWITCH_COUNT-1:0][CW-1:0] count;
  logic [SWITCH_COUNT-1:0][CW-1:0] count_next;

  // Counter saturates at LAST only in the sense that reaching it flips.
  always_comb begin
    flip       = '0;
    count_next = '0;
    for (int i = 0; i < SWITCH_COUNT; i++) begin
      if (sync[i] != switches[i]) begin
        if (count[i] == LAST) begin
          flip[i] = 1'b1;
        end else begin
          count_next[i] = count[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta          <= '0;
      sync          <= '0;
      count         <= '0;
      switches      <= '0;
      change_mask   <= '0;
      changed       <= 1'b0;
      event_pending <= 1'b0;
    end else begin
      meta        <= raw_switches;
      sync        <= meta;
      count       <= count_next;
      switches    <= switches ^ flip;
      change_mask <= flip;
      changed     <= |flip;
      // A new change wins over a same-edge acknowledge.
      if (|flip) begin
        event_pending <= 1'b1;
      end else if (event_ack) begin
        event_pending <= 1'b0;
      end
    end
  end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 SHALL have parameter SWITCH_COUNT, default 18: number of switch inputs.
REQ-002 SHALL have parameter STABLE_CYCLES, default 50000: consecutive synchronized cycles of disagreement needed to accept a new level; legal range is 1 or more.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port raw_switches, input, [0:SWITCH_COUNT-1]: asynchronous board switch levels.
REQ-006 SHALL have port switches, output, [0:SWITCH_COUNT-1]: debounced levels; feeds the memory switch input directly.
REQ-007 SHALL have port change_mask, output, [0:SWITCH_COUNT-1]: bits whose debounced level flipped on the last edge.
REQ-008 SHALL have port changed, output, 1 bit: one-cycle pulse, equal to the OR of change_mask.
REQ-009 SHALL have port event_pending, output, 1 bit: sticky flag meaning at least one debounced change has occurred since the last acknowledge.
REQ-010 SHALL have port event_ack, input, 1 bit: synchronous clear of event_pending.

Function
REQ-011 SHALL pass each raw_switches bit through a two-flop synchronizer before any other logic; only the second flop (sync) is used downstream.
REQ-012 SHALL keep one counter per bit, sized to hold STABLE_CYCLES-1, so counters never wrap.
REQ-013 SHALL handle each bit as follows when sync equals switches: counter cleared to 0.
REQ-014 SHALL handle each bit as follows when sync differs from switches and counter < STABLE_CYCLES-1: counter increments by 1.
REQ-015 SHALL handle each bit as follows when sync differs from switches and counter == STABLE_CYCLES-1: switches bit takes the sync value, counter clears, and the change_mask bit is set for exactly one cycle.
REQ-016 SHALL give a bit that stays constant a latency of exactly 2 + STABLE_CYCLES clock edges, counted from the first edge sampling the new raw level to the edge updating switches.
REQ-017 SHALL ignore any sync disagreement shorter than STABLE_CYCLES consecutive cycles; the bit's counter restarts from 0 on the first agreeing cycle.
REQ-018 SHALL treat bits independently; simultaneous changes on several bits qualifying on the same edge SHALL set all of those change_mask bits together, with a single changed pulse.
REQ-019 SHALL keep change_mask and changed at 0 on every edge where no bit flips.
REQ-020 SHALL set event_pending on the edge where changed is generated, and clear it on an edge sampling event_ack=1 when no change occurs that edge.
REQ-021 SHALL let set win when a change and event_ack=1 occur on the same edge, so event_pending stays 1.
REQ-022 SHALL treat event_ack while event_pending=0 as a no-op.
REQ-023 SHALL, with STABLE_CYCLES=1, accept a new level on the first disagreeing synchronized cycle, for a latency of 3 edges.
REQ-024 SHALL be purely synchronous apart from reset; there are no combinational paths from raw_switches to any output.

Reset
REQ-025 SHALL, while reset=0, immediately force all of the following to 0: synchronizer flops, counters, switches, change_mask, changed, event_pending.
REQ-026 SHALL make reset asserted mid-count discard partial counts; after release, counting restarts from 0 against switches=0.
REQ-027 SHALL, when a switch is already high at reset release, drive the matching switches bit to 1 after exactly 2 + STABLE_CYCLES edges, with a changed pulse and event_pending set.

Verification (bench uses STABLE_CYCLES=4, SWITCH_COUNT=18)
REQ-028 SHALL verify clean press: raw_switches[3] 0->1 held -> switches[3]=1 and change_mask[3]=1 on edge 6 after the change; changed is high for one cycle; event_pending=1.
REQ-029 SHALL verify glitch reject: raw_switches[0] high for 3 cycles then low -> switches stays 0, changed never pulses.
REQ-030 SHALL verify bounce: raw_switches[5] toggles 1,0,1,0,1 one cycle each, then holds 1 -> switches[5] rises exactly 6 edges after the final 0->1 transition.
REQ-031 SHALL verify simultaneous change: raw_switches[0] and raw_switches[17] rise on the same cycle -> change_mask = bits 0 and 17 set in one cycle; a single changed pulse is produced.
REQ-032 SHALL verify ack race: event_ack=1 on the same edge as a new change -> event_pending stays 1; event_ack on the next edge -> event_pending=0.
REQ-033 SHALL verify reset mid-count: assert reset after 2 disagreeing cycles -> all outputs 0 at once; after release with raw held 1, switches rises 6 edges later.
